// File: rtl/fc_layer_pkg.sv
// Shared constants for the fully-connected layer stage: DRAM memory map,
// parameter-block word offsets and one-hot FSM state encodings.
package fc_layer_pkg;

  // DRAM word addresses of each region
  localparam int PARAM_BASE = 0;
  localparam int BIAS_BASE  = 16;
  localparam int VEC_BASE   = 65536;
  localparam int OUT_BASE   = 131072;
  localparam int WGT_BASE   = 196608;

  // Parameter block layout (word offsets from PARAM_BASE)
  localparam int PARAM_N_IN  = 0;
  localparam int PARAM_N_OUT = 1;
  localparam int PARAM_FLAGS = 2;
  localparam int PARAM_WORDS = 3;

  // One-hot FSM encodings
  localparam int ST_W = 8;
  localparam logic [ST_W-1:0] S_IDLE     = 8'b0000_0001;
  localparam logic [ST_W-1:0] S_LD_PARAM = 8'b0000_0010;
  localparam logic [ST_W-1:0] S_CHECK    = 8'b0000_0100;
  localparam logic [ST_W-1:0] S_LD_VEC   = 8'b0000_1000;
  localparam logic [ST_W-1:0] S_LD_BIAS  = 8'b0001_0000;
  localparam logic [ST_W-1:0] S_MAC      = 8'b0010_0000;
  localparam logic [ST_W-1:0] S_WRITE    = 8'b0100_0000;
  localparam logic [ST_W-1:0] S_DONE     = 8'b1000_0000;

endpackage

// File: rtl/fc_vec_buf.sv
// On-chip input vector buffer: 1R1W synchronous RAM, one-cycle read latency.
module fc_vec_buf #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4096,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write port and registered read port share the clock
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  // NOTE: the array has no reset; it is always written in LD_VEC before MAC reads it,
  // and a reset would prevent mapping onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/fc_layer.sv
// Fully-connected layer stage: loads parameters and the pooled input vector
// from DRAM, streams weights/biases, runs one MAC per cycle and writes
// saturated (optionally ReLU-clamped) fixed-point outputs back to DRAM.
module fc_layer
  import fc_layer_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 18,
  parameter int FRAC_BITS  = 16,
  parameter int MAX_IN     = 4096
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [ADDR_WIDTH-1:0] addr_in,
  output logic [ADDR_WIDTH-1:0] addr_out,
  output logic                  dram_en_rd,
  output logic                  dram_en_wr,
  output logic                  done
);

  localparam int ACC_W  = 2*DATA_WIDTH + 16;
  localparam int PROD_W = 2*DATA_WIDTH;
  localparam int BUF_AW = $clog2(MAX_IN);
  localparam int CNT_W  = 16;

  logic [ST_W-1:0]          state;
  logic [CNT_W-1:0]         n_in, n_out;
  logic                     relu_en;
  logic [CNT_W-1:0]         icnt;      // reads issued in the current phase
  logic [CNT_W-1:0]         rcnt;      // read data / products consumed in the current phase
  logic [CNT_W-1:0]         o_cnt;     // current output neuron
  logic                     rd_v1;     // data_in carries the word requested last cycle
  logic [ADDR_WIDTH-1:0]    wgt_addr;  // running o*N_IN+i weight pointer
  logic signed [ACC_W-1:0]  acc;
  logic signed [PROD_W-1:0] product;
  logic                     prod_v;

  logic                     buf_we;
  logic [BUF_AW-1:0]        buf_waddr, buf_raddr;
  logic [DATA_WIDTH-1:0]    buf_dout;

  logic signed [ACC_W-1:0]  acc_shift;
  logic [DATA_WIDTH-1:0]    result;

  // Vector words are written into the buffer the cycle they arrive
  assign buf_we    = (state == S_LD_VEC) && rd_v1;
  assign buf_waddr = rcnt[BUF_AW-1:0];

  fc_vec_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (MAX_IN),
    .AW         (BUF_AW)
  ) u_vec_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (buf_waddr),
    .wdata (data_in),
    .raddr (buf_raddr),
    .rdata (buf_dout)
  );

  // Rescale accumulator to the data format, saturate, then optional ReLU
  // NOTE: every variable gets a value on every path through always_comb, or a latch is inferred.
  always_comb begin
    acc_shift = acc >>> FRAC_BITS;
    if (&acc_shift[ACC_W-1:DATA_WIDTH-1] || ~|acc_shift[ACC_W-1:DATA_WIDTH-1])
      result = acc_shift[DATA_WIDTH-1:0];
    else if (acc_shift[ACC_W-1])
      result = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    else
      result = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    if (relu_en && result[DATA_WIDTH-1]) result = '0;
  end

  // Multiplier stage: registers weight x vector one cycle after both arrive
  always_ff @(posedge clk) begin
    if (srst) begin
      product <= '0;
      prod_v  <= 1'b0;
    end else begin
      product <= PROD_W'($signed(data_in)) * PROD_W'($signed(buf_dout));
      prod_v  <= rd_v1 && (state == S_MAC);
    end
  end

  // Layer FSM, read/write address generation and accumulation
  // NOTE: reset is synchronous and takes priority over every other input, so an
  // in-flight layer is abandoned with no write strobe on the following cycle.
  always_ff @(posedge clk) begin
    if (srst) begin
      state      <= S_IDLE;
      data_out   <= '0;
      addr_in    <= '0;
      addr_out   <= '0;
      dram_en_rd <= 1'b0;
      dram_en_wr <= 1'b0;
      done       <= 1'b0;
      n_in       <= '0;
      n_out      <= '0;
      relu_en    <= 1'b0;
      icnt       <= '0;
      rcnt       <= '0;
      o_cnt      <= '0;
      rd_v1      <= 1'b0;
      wgt_addr   <= '0;
      acc        <= '0;
      buf_raddr  <= '0;
    end else begin
      dram_en_rd <= 1'b0;
      dram_en_wr <= 1'b0;
      done       <= 1'b0;
      rd_v1      <= dram_en_rd;

      case (state)
        S_IDLE: begin
          if (enable) begin
            icnt  <= '0;
            rcnt  <= '0;
            state <= S_LD_PARAM;
          end
        end

        S_LD_PARAM: begin
          if (icnt < CNT_W'(PARAM_WORDS)) begin
            addr_in    <= ADDR_WIDTH'(PARAM_BASE) + ADDR_WIDTH'(icnt);
            dram_en_rd <= 1'b1;
            icnt       <= icnt + 1'b1;
          end
          if (rd_v1) begin
            if (rcnt == CNT_W'(PARAM_N_IN))       n_in    <= data_in[CNT_W-1:0];
            else if (rcnt == CNT_W'(PARAM_N_OUT)) n_out   <= data_in[CNT_W-1:0];
            else if (rcnt == CNT_W'(PARAM_FLAGS)) relu_en <= data_in[0];
            rcnt <= rcnt + 1'b1;
            if (rcnt == CNT_W'(PARAM_WORDS - 1)) state <= S_CHECK;
          end
        end

        S_CHECK: begin
          icnt     <= '0;
          rcnt     <= '0;
          o_cnt    <= '0;
          wgt_addr <= ADDR_WIDTH'(WGT_BASE);
          if (int'(n_in) > MAX_IN || n_out == '0) state <= S_DONE;
          else if (n_in == '0)                    state <= S_LD_BIAS;
          else                                    state <= S_LD_VEC;
        end

        S_LD_VEC: begin
          if (icnt < n_in) begin
            addr_in    <= ADDR_WIDTH'(VEC_BASE) + ADDR_WIDTH'(icnt);
            dram_en_rd <= 1'b1;
            icnt       <= icnt + 1'b1;
          end
          if (rd_v1) begin
            rcnt <= rcnt + 1'b1;
            if (rcnt == n_in - 1'b1) begin
              icnt  <= '0;
              rcnt  <= '0;
              state <= S_LD_BIAS;
            end
          end
        end

        S_LD_BIAS: begin
          if (icnt == '0) begin
            addr_in    <= ADDR_WIDTH'(BIAS_BASE) + ADDR_WIDTH'(o_cnt);
            dram_en_rd <= 1'b1;
            icnt       <= CNT_W'(1);
          end
          if (rd_v1) begin
            acc   <= ACC_W'($signed(data_in)) <<< FRAC_BITS;
            icnt  <= '0;
            rcnt  <= '0;
            state <= (n_in == '0) ? S_WRITE : S_MAC;
          end
        end

        S_MAC: begin
          // Weights are row-major and contiguous, so one running pointer covers o*N_IN+i
          if (icnt < n_in) begin
            addr_in    <= wgt_addr;
            wgt_addr   <= wgt_addr + 1'b1;
            buf_raddr  <= icnt[BUF_AW-1:0];
            dram_en_rd <= 1'b1;
            icnt       <= icnt + 1'b1;
          end
          if (prod_v) begin
            acc  <= acc + ACC_W'(product);
            rcnt <= rcnt + 1'b1;
            if (rcnt == n_in - 1'b1) state <= S_WRITE;
          end
        end

        S_WRITE: begin
          data_out   <= result;
          addr_out   <= ADDR_WIDTH'(OUT_BASE) + ADDR_WIDTH'(o_cnt);
          dram_en_wr <= 1'b1;
          icnt       <= '0;
          rcnt       <= '0;
          if (o_cnt == n_out - 1'b1) begin
            state <= S_DONE;
          end else begin
            o_cnt <= o_cnt + 1'b1;
            state <= S_LD_BIAS;
          end
        end

        S_DONE: begin
          done  <= 1'b1;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_layer.sv
// Self-checking bench for fc_layer: behavioural DRAM, write scoreboard,
// table of single-input vectors plus hand-written multi-cycle sequences.
module tb_fc_layer;

  localparam int DW = 32;
  localparam int AW = 18;
  localparam int MAX_IN = 4096;

  logic          clk;
  logic          srst;
  logic          enable;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic [AW-1:0] addr_in;
  logic [AW-1:0] addr_out;
  logic          dram_en_rd;
  logic          dram_en_wr;
  logic          done;

  fc_layer #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .FRAC_BITS  (16),
    .MAX_IN     (MAX_IN)
  ) dut (
    .clk        (clk),
    .srst       (srst),
    .enable     (enable),
    .data_in    (data_in),
    .data_out   (data_out),
    .addr_in    (addr_in),
    .addr_out   (addr_out),
    .dram_en_rd (dram_en_rd),
    .dram_en_wr (dram_en_wr),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DRAM model and bus monitor ----------------
  logic [DW-1:0] mem [0:262143];
  logic          rd_pend = 1'b0;
  logic [AW-1:0] rd_addr_q = '0;
  int            wr_cnt = 0;
  int            done_cnt = 0;
  int            vec_rd_cnt = 0;
  int            wgt_rd_cnt = 0;
  int            both_cnt = 0;
  logic [AW-1:0] obs_addr [256];
  logic [DW-1:0] obs_data [256];

  always @(negedge clk) begin
    rd_pend   <= dram_en_rd;
    rd_addr_q <= addr_in;
    if (dram_en_rd && addr_in >= 18'd65536 && addr_in < 18'd131072) vec_rd_cnt <= vec_rd_cnt + 1;
    if (dram_en_rd && addr_in >= 18'd196608) wgt_rd_cnt <= wgt_rd_cnt + 1;
    if (dram_en_rd && dram_en_wr) both_cnt <= both_cnt + 1;
    if (dram_en_wr) begin
      obs_addr[wr_cnt % 256] <= addr_out;
      obs_data[wr_cnt % 256] <= data_out;
      wr_cnt <= wr_cnt + 1;
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  always @(posedge clk) begin
    if (rd_pend) data_in <= mem[rd_addr_q];
  end

  // ---------------- scoreboard and checking ----------------
  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t exp_q [$];
  int  checks = 0;
  int  failures = 0;
  int  consumed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic score(input string tag);
    wr_t e;
    while (consumed < wr_cnt) begin
      if (exp_q.size() == 0) begin
        check({tag, "_extra_wr"}, 64'(obs_addr[consumed % 256]), 64'hDEAD);
      end else begin
        e = exp_q.pop_front();
        check({tag, "_wr_addr"}, 64'(obs_addr[consumed % 256]), 64'(e.addr));
        check({tag, "_wr_data"}, 64'(obs_data[consumed % 256]), 64'(e.data));
      end
      consumed++;
    end
  endtask

  task automatic push_exp(input int o, input logic [DW-1:0] d);
    wr_t e;
    e.addr = AW'(131072 + o);
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Start a layer (or two back-to-back with enable held), score writes, check done/counts
  task automatic do_test(input string tag, input int n_done, input bit hold, input int exp_wr);
    int  wr_base;
    int  done_base;
    int  cyc;
    int  seen;
    bit  drop_next;
    wr_base   = wr_cnt;
    done_base = done_cnt;
    consumed  = wr_cnt;
    cyc       = 0;
    seen      = 0;
    drop_next = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    if (!hold) begin
      @(negedge clk);
      enable = 1'b0;
    end
    while (seen < n_done && cyc < 4000) begin
      @(negedge clk);
      #1;
      cyc++;
      score(tag);
      seen = done_cnt - done_base;
      if (hold && seen >= 1) begin
        if (drop_next) enable = 1'b0;
        drop_next = 1'b1;
      end
    end
    enable = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1;
      score(tag);
    end
    check({tag, "_done_pulses"}, 64'(done_cnt - done_base), 64'(n_done));
    check({tag, "_n_writes"}, 64'(wr_cnt - wr_base), 64'(exp_wr));
    check({tag, "_missing_wr"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic set_params(input int n_in, input int n_out, input bit relu);
    mem[0] = DW'(n_in);
    mem[1] = DW'(n_out);
    mem[2] = {31'd0, relu};
  endtask

  // x=[1,2,3,4], w0=[1,1,1,1], w1=[-1,0,0,0], b=[0.5,0]
  task automatic load_test_a(input bit relu);
    set_params(4, 2, relu);
    mem[16] = 32'h0000_8000;
    mem[17] = 32'h0000_0000;
    for (int i = 0; i < 4; i++) mem[65536 + i] = DW'((i + 1) << 16);
    for (int i = 0; i < 4; i++) mem[196608 + i] = 32'h0001_0000;
    mem[196612] = 32'hFFFF_0000;
    for (int i = 1; i < 4; i++) mem[196612 + i] = 32'h0000_0000;
  endtask

  typedef struct {
    logic [DW-1:0] x;
    logic [DW-1:0] w;
    logic [DW-1:0] b;
    bit            relu;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int vb;
    int wb;
    int wr_base;
    int cyc;

    for (int a = 0; a < 262144; a++) mem[a] = '0;
    data_in = '0;
    enable  = 1'b0;
    srst    = 1'b1;

    // ---- reset state ----
    repeat (3) @(negedge clk);
    check("rst_data_out", 64'(data_out), 64'd0);
    check("rst_addr_in", 64'(addr_in), 64'd0);
    check("rst_addr_out", 64'(addr_out), 64'd0);
    check("rst_en_rd", 64'(dram_en_rd), 64'd0);
    check("rst_en_wr", 64'(dram_en_wr), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    srst = 1'b0;

    // ---- worked example, enable held high: two back-to-back layers ----
    load_test_a(1'b0);
    for (int r = 0; r < 2; r++) begin
      push_exp(0, 32'h000A_8000);
      push_exp(1, 32'hFFFF_0000);
    end
    do_test("exA_hold", 2, 1'b1, 4);

    // ---- worked example with ReLU ----
    load_test_a(1'b1);
    push_exp(0, 32'h000A_8000);
    push_exp(1, 32'h0000_0000);
    do_test("exA_relu", 1, 1'b0, 2);

    // ---- single-input vectors: saturation, sign, rounding, ReLU ----
    vecs[0] = '{32'h7FFF_0000, 32'h7FFF_0000, 32'h0000_0000, 1'b0, 32'h7FFF_FFFF};
    vecs[1] = '{32'h7FFF_0000, 32'h8001_0000, 32'h0000_0000, 1'b0, 32'h8000_0000};
    vecs[2] = '{32'h0002_0000, 32'h0001_8000, 32'h0001_0000, 1'b0, 32'h0004_0000};
    vecs[3] = '{32'h0002_0000, 32'hFFFE_8000, 32'h0001_0000, 1'b0, 32'hFFFE_0000};
    vecs[4] = '{32'h0002_0000, 32'hFFFE_8000, 32'h0001_0000, 1'b1, 32'h0000_0000};
    vecs[5] = '{32'h0000_8000, 32'h0000_8000, 32'h0000_0000, 1'b0, 32'h0000_4000};
    vecs[6] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 32'hFFFF_FFFF};
    vecs[7] = '{32'h0001_0000, 32'h0001_0000, 32'h7FFF_FFFF, 1'b0, 32'h7FFF_FFFF};
    for (int v = 0; v < 8; v++) begin
      set_params(1, 1, vecs[v].relu);
      mem[16]     = vecs[v].b;
      mem[65536]  = vecs[v].x;
      mem[196608] = vecs[v].w;
      push_exp(0, vecs[v].exp);
      do_test($sformatf("vec%0d", v), 1, 1'b0, 1);
    end

    // ---- N_IN=0: outputs are the biases, no vector/weight traffic ----
    set_params(0, 3, 1'b0);
    mem[16] = 32'h0001_0000;
    mem[17] = 32'h0002_0000;
    mem[18] = 32'h0003_0000;
    for (int o = 0; o < 3; o++) push_exp(o, DW'((o + 1) << 16));
    vb = vec_rd_cnt;
    wb = wgt_rd_cnt;
    do_test("nin0", 1, 1'b0, 3);
    check("nin0_vec_reads", 64'(vec_rd_cnt - vb), 64'd0);
    check("nin0_wgt_reads", 64'(wgt_rd_cnt - wb), 64'd0);

    // ---- parameter errors ----
    set_params(MAX_IN + 1, 1, 1'b0);
    vb = vec_rd_cnt;
    do_test("nin_over", 1, 1'b0, 0);
    check("nin_over_vec_reads", 64'(vec_rd_cnt - vb), 64'd0);
    set_params(2, 0, 1'b0);
    do_test("nout0", 1, 1'b0, 0);

    // ---- synchronous reset mid-MAC, then full rerun ----
    load_test_a(1'b0);
    wr_base = wr_cnt;
    wb = wgt_rd_cnt;
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    cyc = 0;
    while (wgt_rd_cnt == wb && cyc < 200) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    check("srst_reached_mac", 64'(wgt_rd_cnt > wb), 64'd1);
    @(negedge clk);
    srst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("srst_en_wr%0d", k), 64'(dram_en_wr), 64'd0);
      check($sformatf("srst_done%0d", k), 64'(done), 64'd0);
    end
    check("srst_en_rd", 64'(dram_en_rd), 64'd0);
    check("srst_addr_in", 64'(addr_in), 64'd0);
    srst = 1'b0;
    @(negedge clk);
    #1;
    check("srst_no_writes", 64'(wr_cnt - wr_base), 64'd0);
    push_exp(0, 32'h000A_8000);
    push_exp(1, 32'hFFFF_0000);
    do_test("rerun", 1, 1'b0, 2);

    check("rd_wr_overlap", 64'(both_cnt), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
